// File: rtl/uart_tx_fifo_bridge.sv
// uart_tx_fifo_bridge
//   Byte FIFO in front of uart_tx. Producers push bytes, and the FSM drains them
//   one at a time using the tx_start / tx_busy handshake. Byte order is preserved.
//
//   Optional feature macro: UART_TX_BRIDGE_TIMEOUT_EN
//     When it is defined, a watchdog runs in WAIT_HI. If tx_busy never rises
//     within TIMEOUT_CYCLES clocks, the FSM pulses o_tx_err, abandons the popped
//     byte and returns to IDLE.
//     When it is undefined, there is no o_tx_err port and WAIT_HI waits forever.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no byte in flight; launches the FIFO head when not empty
//   WAIT_HI | byte launched, waiting for uart_tx to raise tx_busy
//   WAIT_LO | uart_tx busy, waiting for tx_busy to fall (byte complete)
module uart_tx_fifo_bridge #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [7:0]               i_push_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_drop,
    output logic                     o_tx_start,
    output logic [7:0]               o_tx_data,
    input  logic                     i_tx_busy
`ifdef UART_TX_BRIDGE_TIMEOUT_EN
    ,
    output logic                     o_tx_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Catch illegal parameterisations at elaboration rather than in silicon.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_fifo_bridge: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_HI = 2'd1,
        S_WAIT_LO = 2'd2
    } state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_drop;
    state_t        r_state;
    logic          r_tx_start;
    logic [7:0]    r_tx_data;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop;

`ifdef UART_TX_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // Loaded with TIMEOUT_CYCLES-1 at launch so the terminal count (zero) is hit
    // on the TIMEOUT_CYCLES-th edge spent in WAIT_HI.
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);

    logic [TW-1:0] r_timer;
    logic          r_tx_err;
`endif

    // Occupancy is the single source of full/empty; a full FIFO never bypasses,
    // even when a pop happens on the same edge.
    assign w_full    = (r_count == CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_push_ok = i_push & ~w_full;
    assign w_pop     = (r_state == S_IDLE) & ~w_empty;

    // Storage array; written only for accepted pushes.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    // Write pointer, occupancy and the drop pulse for pushes rejected while full.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_count <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= i_push & w_full;
            if (w_push_ok) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Launch/handshake FSM; owns the read pointer and all uart-facing outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_rptr     <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
`ifdef UART_TX_BRIDGE_TIMEOUT_EN
            r_timer    <= '0;
            r_tx_err   <= 1'b0;
`endif
        end else begin
            r_tx_start <= 1'b0;
`ifdef UART_TX_BRIDGE_TIMEOUT_EN
            r_tx_err   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_tx_data  <= r_mem[r_rptr];
                        r_rptr     <= r_rptr + PTR_ONE;
                        r_tx_start <= 1'b1;
                        r_state    <= S_WAIT_HI;
`ifdef UART_TX_BRIDGE_TIMEOUT_EN
                        r_timer    <= TMR_LOAD;
`endif
                    end
                end
                S_WAIT_HI: begin
                    if (i_tx_busy) begin
                        r_state <= S_WAIT_LO;
`ifdef UART_TX_BRIDGE_TIMEOUT_EN
                    end else if (r_timer == '0) begin
                        r_tx_err <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - TMR_ONE;
`endif
                    end
                end
                S_WAIT_LO: begin
                    if (!i_tx_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_drop     = r_drop;
    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
`ifdef UART_TX_BRIDGE_TIMEOUT_EN
    assign o_tx_err   = r_tx_err;
`endif

endmodule
